// File: rtl/comparador_pkg.sv
// Shared encodings for the comparator monitor: confirmed-relation codes and
// the flag-to-relation decoder with its one-hot validity bit.
package comparador_pkg;

    localparam logic [1:0] EST_INICIO = 2'b00;
    localparam logic [1:0] EST_MAIOR  = 2'b01;
    localparam logic [1:0] EST_MENOR  = 2'b10;
    localparam logic [1:0] EST_IGUAL  = 2'b11;

    typedef struct packed {
        logic       valida;
        logic [1:0] rel;
    } relacao_t;

    // Any pattern other than exactly one flag set is reported as invalid.
    function automatic relacao_t codificaFlags(input logic maior, input logic menor,
                                               input logic igual);
        relacao_t r;
        case ({maior, menor, igual})
            3'b100:  r = '{valida: 1'b1, rel: EST_MAIOR};
            3'b010:  r = '{valida: 1'b1, rel: EST_MENOR};
            3'b001:  r = '{valida: 1'b1, rel: EST_IGUAL};
            default: r = '{valida: 1'b0, rel: EST_INICIO};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module contador_saturado #(
    parameter int CONT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [CONT_W-1:0] valor
);

    localparam logic [CONT_W-1:0] MAXIMO = {CONT_W{1'b1}};

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            valor <= {CONT_W{1'b0}};
        end else if (clr) begin
            valor <= {CONT_W{1'b0}};
        end else if (inc && (valor != MAXIMO)) begin
            valor <= valor + CONT_W'(1);
        end else begin
            valor <= valor;
        end
    end

endmodule

// File: rtl/monitor_comparacao.sv
// Persistence filter for the magnitude comparator flags: confirms a relation after
// N_CONFIRMA consecutive valid samples and keeps entry counters plus a sticky error.
module monitor_comparacao
    import comparador_pkg::*;
#(
    parameter int N_CONFIRMA = 3,
    parameter int CONT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              amostra_valida,
    input  logic              AmaiorB,
    input  logic              AmenorB,
    input  logic              AigualB,
    input  logic              limpar,
    output logic [1:0]        estado,
    output logic              mudanca,
    output logic [CONT_W-1:0] cont_maior,
    output logic [CONT_W-1:0] cont_menor,
    output logic [CONT_W-1:0] cont_igual,
    output logic              erro
);

    localparam int              RUN_W   = $clog2(N_CONFIRMA + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(N_CONFIRMA);

    relacao_t         relacao_s;
    logic [1:0]       candidato_r;
    logic [1:0]       candNext_s;
    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] runNext_s;
    logic             erroAmostra_s;
    logic             confirma_s;
    logic             incMaior_s;
    logic             incMenor_s;
    logic             incIgual_s;

    // Next candidate/run; idle cycles hold both so gaps never break a run.
    always_comb begin
        relacao_s     = codificaFlags(AmaiorB, AmenorB, AigualB);
        candNext_s    = candidato_r;
        runNext_s     = run_r;
        erroAmostra_s = 1'b0;
        if (amostra_valida) begin
            if (relacao_s.valida) begin
                if (relacao_s.rel == candidato_r) begin
                    if (run_r == RUN_MAX) begin
                        runNext_s = run_r;
                    end else begin
                        runNext_s = run_r + RUN_W'(1);
                    end
                end else begin
                    candNext_s = relacao_s.rel;
                    runNext_s  = RUN_W'(1);
                end
            end else begin
                erroAmostra_s = 1'b1;
                candNext_s    = EST_INICIO;
                runNext_s     = {RUN_W{1'b0}};
            end
        end else begin
            candNext_s = candidato_r;
            runNext_s  = run_r;
        end
        confirma_s = amostra_valida && relacao_s.valida && (runNext_s == RUN_MAX)
                     && (candNext_s != estado);
        incMaior_s = confirma_s && (candNext_s == EST_MAIOR);
        incMenor_s = confirma_s && (candNext_s == EST_MENOR);
        incIgual_s = confirma_s && (candNext_s == EST_IGUAL);
    end

    // Run tracking, confirmed relation, change pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            candidato_r <= EST_INICIO;
            run_r       <= {RUN_W{1'b0}};
            estado      <= EST_INICIO;
            mudanca     <= 1'b0;
            erro        <= 1'b0;
        end else begin
            candidato_r <= candNext_s;
            run_r       <= runNext_s;
            mudanca     <= confirma_s;
            estado      <= confirma_s ? candNext_s : estado;
            // A fresh error outranks limpar on the same edge.
            if (erroAmostra_s) begin
                erro <= 1'b1;
            end else if (limpar) begin
                erro <= 1'b0;
            end else begin
                erro <= erro;
            end
        end
    end

    contador_saturado #(.CONT_W(CONT_W)) uContMaior (
        .clk(clk), .rst(rst), .inc(incMaior_s), .clr(limpar), .valor(cont_maior)
    );

    contador_saturado #(.CONT_W(CONT_W)) uContMenor (
        .clk(clk), .rst(rst), .inc(incMenor_s), .clr(limpar), .valor(cont_menor)
    );

    contador_saturado #(.CONT_W(CONT_W)) uContIgual (
        .clk(clk), .rst(rst), .inc(incIgual_s), .clr(limpar), .valor(cont_igual)
    );

endmodule

// File: tb/tb_monitor_comparacao.sv
// Scoreboard bench: expected snapshots are queued per confirmation and checked
// whenever the monitor sees mudanca; a second instance covers CONT_W=2 saturation.
module tb_monitor_comparacao;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valida = 1'b0, fMaior = 1'b0, fMenor = 1'b0, fIgual = 1'b0, limpar = 1'b0;
    logic [1:0] estado;
    logic       mudanca, erro;
    logic [7:0] contMaior, contMenor, contIgual;

    logic       valida2 = 1'b0, gMaior = 1'b0, gMenor = 1'b0, gIgual = 1'b0;
    logic [1:0] estado2;
    logic       mudanca2, erro2;
    logic [1:0] contMaior2, contMenor2, contIgual2;

    int nTests = 0;
    int nFail  = 0;

    typedef struct packed {
        logic [1:0] est;
        logic [7:0] cm;
        logic [7:0] cn;
        logic [7:0] ci;
        logic       er;
    } snap_t;

    snap_t expQ[$];

    always #5 clk = ~clk;

    monitor_comparacao #(.N_CONFIRMA(3), .CONT_W(8)) dut (
        .clk(clk), .rst(rst), .amostra_valida(valida),
        .AmaiorB(fMaior), .AmenorB(fMenor), .AigualB(fIgual), .limpar(limpar),
        .estado(estado), .mudanca(mudanca), .cont_maior(contMaior),
        .cont_menor(contMenor), .cont_igual(contIgual), .erro(erro)
    );

    monitor_comparacao #(.N_CONFIRMA(3), .CONT_W(2)) dut2 (
        .clk(clk), .rst(rst), .amostra_valida(valida2),
        .AmaiorB(gMaior), .AmenorB(gMenor), .AigualB(gIgual), .limpar(1'b0),
        .estado(estado2), .mudanca(mudanca2), .cont_maior(contMaior2),
        .cont_menor(contMenor2), .cont_igual(contIgual2), .erro(erro2)
    );

    // Monitor: every change pulse must match the next queued snapshot.
    always @(negedge clk) begin
        if (mudanca) begin
            snap_t got;
            snap_t exp;
            got = '{est: estado, cm: contMaior, cn: contMenor, ci: contIgual, er: erro};
            nTests++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("FAIL unexpected_pulse: got estado=%b cm=%0d cn=%0d ci=%0d erro=%b, required no pulse",
                         got.est, got.cm, got.cn, got.ci, got.er);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("FAIL pulse_snapshot: got estado=%b cm=%0d cn=%0d ci=%0d erro=%b, required estado=%b cm=%0d cn=%0d ci=%0d erro=%b",
                             got.est, got.cm, got.cn, got.ci, got.er,
                             exp.est, exp.cm, exp.cn, exp.ci, exp.er);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        nTests++;
        if (got != req) begin
            nFail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic pushExp(input logic [1:0] est, input int cm, input int cn,
                           input int ci, input logic er);
        expQ.push_back('{est: est, cm: 8'(cm), cn: 8'(cn), ci: 8'(ci), er: er});
    endtask

    // One valid sample on instance 1, followed by one idle cycle.
    task automatic sample(input logic [2:0] f, input logic lim);
        @(negedge clk);
        {fMaior, fMenor, fIgual} = f;
        valida = 1'b1;
        limpar = lim;
        @(negedge clk);
        valida = 1'b0;
        limpar = 1'b0;
    endtask

    task automatic sample2(input logic [2:0] f);
        @(negedge clk);
        {gMaior, gMenor, gIgual} = f;
        valida2 = 1'b1;
        @(negedge clk);
        valida2 = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        doReset(2);
        check("reset_estado", estado, 0);
        check("reset_mudanca", mudanca, 0);
        check("reset_counters", contMaior + contMenor + contIgual, 0);
        check("reset_erro", erro, 0);

        // Three A>B samples confirm MAIOR; the fourth is a silent re-confirm.
        sample(3'b100, 1'b0);
        sample(3'b100, 1'b0);
        check("maior_not_yet", estado, 0);
        pushExp(2'b01, 1, 0, 0, 1'b0);
        sample(3'b100, 1'b0);
        sample(3'b100, 1'b0);
        check("maior_recfm_count", contMaior, 1);

        // Switch to MENOR with idle gaps between samples.
        sample(3'b100, 1'b0);
        sample(3'b100, 1'b0);
        sample(3'b010, 1'b0);
        sample(3'b010, 1'b0);
        check("menor_before_5th", estado, 1);
        pushExp(2'b10, 1, 1, 0, 1'b0);
        sample(3'b010, 1'b0);

        // Non-one-hot sample breaks the IGUAL run and sets the sticky error.
        sample(3'b001, 1'b0);
        sample(3'b001, 1'b0);
        sample(3'b110, 1'b0);
        sample(3'b001, 1'b0);
        check("erro_sticky", erro, 1);
        check("run_broken_estado", estado, 2);
        sample(3'b001, 1'b0);
        pushExp(2'b11, 1, 1, 1, 1'b1);
        sample(3'b001, 1'b0);

        // limpar on the confirming edge: counters and erro clear, pulse still fires.
        sample(3'b010, 1'b0);
        sample(3'b010, 1'b0);
        pushExp(2'b10, 0, 0, 0, 1'b0);
        sample(3'b010, 1'b1);
        check("limpar_cont_menor", contMenor, 0);

        // Invalid sample together with limpar: the new error wins.
        sample(3'b000, 1'b1);
        check("erro_beats_limpar", erro, 1);

        // Reset mid-run discards the partial run.
        sample(3'b100, 1'b0);
        sample(3'b100, 1'b0);
        doReset(1);
        check("midrun_reset_estado", estado, 0);
        check("midrun_reset_erro", erro, 0);
        sample(3'b100, 1'b0);
        check("no_confirm_after_reset", estado, 0);
        sample(3'b100, 1'b0);
        pushExp(2'b01, 1, 0, 0, 1'b0);
        sample(3'b100, 1'b0);

        // CONT_W=2 instance: four confirmations of each relation saturate at 3.
        for (int k = 0; k < 4; k++) begin
            repeat (3) sample2(3'b100);
            repeat (3) sample2(3'b010);
            if (k == 2) check("sat2_maior_at_3", contMaior2, 3);
        end
        check("sat2_maior_nowrap", contMaior2, 3);
        check("sat2_menor_nowrap", contMenor2, 3);
        check("sat2_estado", estado2, 2);

        repeat (3) @(negedge clk);
        check("pending_pulses", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
